priority_scanner: RTL

PRIORITY_SCANNER -- requirements
Module: priority_scanner

---
 rtl/priority_scanner.sv | 127 ++++++++++++
 1 files changed

// File: rtl/priority_scanner.sv
// Repeatedly picks the highest-priority live entry (lowest index on ties) from a captured
// table, hands it out over a valid/ready port, retires it, and pulses done when none remain.
module priority_scanner #(
  parameter int NSQ = 64,
  parameter int PW  = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [NSQ*PW-1:0]         prio_in,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [$clog2(NSQ)-1:0]    out_sq,
  output logic [PW-1:0]             out_prio,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(NSQ+1)-1:0]  count
);

  localparam int SW = $clog2(NSQ);
  localparam int CW = $clog2(NSQ+1);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [NSQ*PW-1:0]   table_q, table_d;
  logic                out_valid_q, out_valid_d;
  logic [SW-1:0]       out_sq_q, out_sq_d;
  logic [PW-1:0]       out_prio_q, out_prio_d;
  logic [CW-1:0]       count_q, count_d;

  logic [SW-1:0]       sel_idx;
  logic [PW-1:0]       sel_prio;

  // Strict greater-than keeps the lowest index among equal priorities.
  always_comb begin
    sel_idx  = '0;
    sel_prio = '0;
    for (int i = 0; i < NSQ; i++) begin
      if (table_q[PW*i +: PW] > sel_prio) begin
        sel_prio = table_q[PW*i +: PW];
        sel_idx  = SW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      table_q     <= '0;
      out_valid_q <= 1'b0;
      out_sq_q    <= '0;
      out_prio_q  <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      table_q     <= table_d;
      out_valid_q <= out_valid_d;
      out_sq_q    <= out_sq_d;
      out_prio_q  <= out_prio_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = SCAN;
        SCAN:    state_d = (sel_prio != '0) ? EMIT : DONE;
        EMIT:    if (out_ready) state_d = SCAN;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next-state; abort freezes table and count and only drops valid.
  always_comb begin
    table_d     = table_q;
    out_valid_d = out_valid_q;
    out_sq_d    = out_sq_q;
    out_prio_d  = out_prio_q;
    count_d     = count_q;
    if (abort) begin
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            table_d = prio_in;
            count_d = '0;
          end
        end
        SCAN: begin
          if (sel_prio != '0) begin
            out_valid_d = 1'b1;
            out_sq_d    = sel_idx;
            out_prio_d  = sel_prio;
          end
        end
        EMIT: begin
          if (out_ready) begin
            table_d[PW*out_sq_q +: PW] = '0;
            count_d     = count_q + CW'(1);
            out_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE) && !abort;
  end

  assign out_valid = out_valid_q;
  assign out_sq    = out_sq_q;
  assign out_prio  = out_prio_q;
  assign count     = count_q;

endmodule
